// File: rtl/sample_acquisition_az_multi_pkg.sv
// Shared encodings for the auto-zero acquisition sequencers.
// The state encoding lives here so the sibling non-AZ sequencer can reuse it.
package sample_acquisition_az_multi_pkg;

  localparam logic SW_PC_BOOT   = 1'b0;
  localparam logic SW_PC_SIGNAL = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_PC_BOOT,
    ST_HI_MUX,
    ST_PC_SIG,
    ST_HI_ACK,
    ST_HI_WAIT,
    ST_LO_BOOT,
    ST_LO_MUX,
    ST_LO_ACK,
    ST_LO_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_PARK
  } state_t;

endpackage

// File: rtl/sample_acquisition_az_multi_settle_timer.sv
// Settle down-counter: load on phase entry, count to zero, flag zero.
module settle_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sample_acquisition_az_multi.sv
// Multi-channel auto-zero acquisition sequencer: walks the AZ mux over N_CH hi inputs,
// optionally interleaving a LO sample, and hands each sample to the ADC handshake.
module sample_acquisition_az_multi
  import sample_acquisition_az_multi_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CH_W  = 3,
  parameter int CNT_W = 32,
  parameter int NS_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm_trigger,
  input  logic              az_enable,
  input  logic [N_CH*4-1:0] azmux_hi_val,
  input  logic [3:0]        azmux_lo_val,
  input  logic [CNT_W-1:0]  p_clk_count_precharge,
  input  logic [NS_W-1:0]   p_sample_count,
  input  logic              adc_measure_valid,
  output logic              adc_measure_trig,
  output logic              sw_pc_ctl,
  output logic [3:0]        azmux,
  output logic              led0,
  output logic [CH_W:0]     status_out,
  output logic              done,
  output logic [1:0]        monitor
);

  state_t            state, state_n;
  logic [1:0]        arm_sr;
  logic              arm_rise, arm_fall;
  logic [CH_W-1:0]   ch, ch_n;
  logic [NS_W-1:0]   nsamp, nsamp_n, nsamp_inc;
  logic              trig_n, pc_n, led_n;
  logic [3:0]        azmux_n;
  logic [CH_W:0]     status_n;
  logic              settle_done;
  logic [3:0]        hi_code [2**CH_W];

  // Unused channel slots read as zero so the index never needs range checks.
  for (genvar k = 0; k < 2**CH_W; k++) begin : g_hi
    if (k < N_CH) begin : g_used
      assign hi_code[k] = azmux_hi_val[4*k +: 4];
    end else begin : g_unused
      assign hi_code[k] = 4'h0;
    end
  end

  assign arm_rise  = (arm_sr == 2'b01);
  assign arm_fall  = (arm_sr == 2'b10);
  assign nsamp_inc = nsamp + NS_W'(1);

  settle_timer #(.CNT_W(CNT_W)) u_settle (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state_n != state),
    .load_val (p_clk_count_precharge),
    .zero     (settle_done)
  );

  always_comb begin
    state_n   = state;
    trig_n    = adc_measure_trig;
    pc_n      = sw_pc_ctl;
    azmux_n   = azmux;
    led_n     = led0;
    status_n  = status_out;
    ch_n      = ch;
    nsamp_n   = nsamp;
    // Arm edges pre-empt whatever phase is running and abandon any open measurement.
    if (arm_rise) begin
      state_n = ST_START;
      trig_n  = 1'b0;
    end else if (arm_fall && state != ST_IDLE) begin
      state_n = ST_PARK;
      trig_n  = 1'b0;
      pc_n    = SW_PC_BOOT;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_START: begin
          trig_n  = 1'b0;
          ch_n    = '0;
          nsamp_n = '0;
          state_n = ST_PC_BOOT;
        end
        ST_PC_BOOT: begin
          pc_n = SW_PC_BOOT;
          if (settle_done) state_n = ST_HI_MUX;
        end
        ST_HI_MUX: begin
          azmux_n = hi_code[ch];
          if (settle_done) state_n = ST_PC_SIG;
        end
        ST_PC_SIG: begin
          pc_n = SW_PC_SIGNAL;
          if (settle_done) begin
            trig_n  = 1'b1;
            state_n = ST_HI_ACK;
          end
        end
        ST_HI_ACK: begin
          if (!adc_measure_valid) begin
            trig_n  = 1'b0;
            led_n   = 1'b1;
            state_n = ST_HI_WAIT;
          end
        end
        ST_HI_WAIT: begin
          if (adc_measure_valid) begin
            status_n = {ch, 1'b1};
            nsamp_n  = (nsamp == '1) ? nsamp : nsamp_inc;
            if (p_sample_count != '0 && nsamp_inc == p_sample_count) begin
              pc_n    = SW_PC_BOOT;
              state_n = ST_DONE;
            end else if (az_enable) begin
              state_n = ST_LO_BOOT;
            end else begin
              state_n = ST_NEXT;
            end
          end
        end
        ST_LO_BOOT: begin
          pc_n = SW_PC_BOOT;
          if (settle_done) state_n = ST_LO_MUX;
        end
        ST_LO_MUX: begin
          azmux_n = azmux_lo_val;
          if (settle_done) begin
            trig_n  = 1'b1;
            led_n   = 1'b0;
            state_n = ST_LO_ACK;
          end
        end
        ST_LO_ACK: begin
          if (!adc_measure_valid) begin
            trig_n  = 1'b0;
            state_n = ST_LO_WAIT;
          end
        end
        ST_LO_WAIT: begin
          if (adc_measure_valid) begin
            status_n = {ch, 1'b0};
            state_n  = ST_NEXT;
          end
        end
        ST_NEXT: begin
          ch_n    = (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
          state_n = ST_PC_BOOT;
        end
        ST_DONE, ST_PARK: begin
          pc_n   = SW_PC_BOOT;
          trig_n = 1'b0;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      arm_sr           <= 2'b00;
      adc_measure_trig <= 1'b0;
      sw_pc_ctl        <= SW_PC_BOOT;
      azmux            <= 4'h0;
      led0             <= 1'b0;
      status_out       <= '0;
      ch               <= '0;
      nsamp            <= '0;
    end else begin
      state            <= state_n;
      arm_sr           <= {arm_sr[0], arm_trigger};
      adc_measure_trig <= trig_n;
      sw_pc_ctl        <= pc_n;
      azmux            <= azmux_n;
      led0             <= led_n;
      status_out       <= status_n;
      ch               <= ch_n;
      nsamp            <= nsamp_n;
    end
  end

  assign done    = (state == ST_DONE);
  assign monitor = {(azmux != azmux_lo_val) && (state != ST_IDLE), adc_measure_trig};

endmodule
